// File: rtl/uc_stack.sv
// Control unit for the single-cycle microcontroller: opcode decode, registered zero flag and
// a LIFO return-address stack serving JAL/RET with zero-latency return.
module uc_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [5:0]               opcode,
    input  logic                     z,
    input  logic [AW-1:0]            pc_plus1,
    output logic                     s_inc,
    output logic                     s_inm,
    output logic                     we3,
    output logic                     wez,
    output logic [2:0]               op,
    output logic                     s_ret,
    output logic [AW-1:0]            ret_addr,
    output logic                     zflag,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stk_ovf,
    output logic                     stk_unf
);

    localparam int unsigned IW  = $clog2(DEPTH);
    localparam int unsigned SPW = IW + 1;

    logic [AW-1:0]  stack_q [DEPTH];
    logic [SPW-1:0] sp_q;
    logic           zflag_q;
    logic           ovf_q;
    logic           unf_q;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;
    logic [IW-1:0]  top_idx;

    assign full    = (sp_q == SPW'(DEPTH));
    assign empty   = (sp_q == '0);
    // Low bits wrap correctly when full: DEPTH-1 is the top entry.
    assign top_idx = sp_q[IW-1:0] - 1'b1;

    always_comb begin
        s_inc = 1'b1;
        s_inm = 1'b0;
        we3   = 1'b0;
        wez   = 1'b0;
        op    = 3'd0;
        s_ret = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        if (!reset) begin
            if (!opcode[5]) begin
                op  = opcode[4:2];
                we3 = 1'b1;
                wez = 1'b1;
            end else begin
                case (opcode)
                    6'b100000: begin
                        we3   = 1'b1;
                        s_inm = 1'b1;
                    end
                    6'b100001: s_inc = 1'b0;
                    6'b100010: s_inc = ~zflag_q;
                    6'b100011: s_inc = zflag_q;
                    6'b100100: begin
                        s_inc = 1'b0;
                        push  = 1'b1;
                    end
                    6'b100101: begin
                        s_ret = 1'b1;
                        pop   = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign ret_addr = empty ? '0 : stack_q[top_idx];

    always_ff @(posedge clk) begin
        if (reset) begin
            zflag_q <= 1'b0;
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wez) zflag_q <= z;
            if (push) begin
                if (full) ovf_q <= 1'b1;
                else      sp_q  <= sp_q + 1'b1;
            end
            if (pop) begin
                if (empty) unf_q <= 1'b1;
                else       sp_q  <= sp_q - 1'b1;
            end
        end
    end

    // Contents need no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !full && !reset) stack_q[sp_q[IW-1:0]] <= pc_plus1;
    end

    assign zflag   = zflag_q;
    assign sp      = sp_q;
    assign stk_ovf = ovf_q;
    assign stk_unf = unf_q;

endmodule

// File: tb/tb_uc_stack.sv
// Bench for uc_stack: vector table plus JAL/RET corner sequences, checked through a
// scoreboard queue by a monitor sampling before and after each clock edge.
module tb_uc_stack;

    localparam logic [5:0] OP_LI  = 6'b100000;
    localparam logic [5:0] OP_J   = 6'b100001;
    localparam logic [5:0] OP_JZ  = 6'b100010;
    localparam logic [5:0] OP_JNZ = 6'b100011;
    localparam logic [5:0] OP_JAL = 6'b100100;
    localparam logic [5:0] OP_RET = 6'b100101;
    localparam logic [5:0] OP_NOP = 6'b111111;

    // {s_inc, s_inm, we3, wez, op[2:0], s_ret}
    localparam logic [7:0] C_NOP = 8'b1000_0000;
    localparam logic [7:0] C_JMP = 8'b0000_0000;
    localparam logic [7:0] C_RET = 8'b1000_0001;
    localparam logic [7:0] C_LI  = 8'b1110_0000;

    typedef struct {
        string       name;
        logic        rst;
        logic [5:0]  opc;
        logic        z;
        logic [9:0]  pc;
        logic [7:0]  ctl;
        logic [9:0]  ret;
        logic [3:0]  sp;
        logic        zf;
        logic        ovf;
        logic        unf;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       z;
    logic [9:0] pc_plus1;
    logic       s_inc, s_inm, we3, wez, s_ret, zflag, stk_ovf, stk_unf;
    logic [2:0] op;
    logic [9:0] ret_addr;
    logic [3:0] sp;

    int checks = 0;
    int errors = 0;
    vec_t sb[$];
    vec_t tbl[$];

    uc_stack #(.DEPTH(8), .AW(10)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .z(z), .pc_plus1(pc_plus1),
        .s_inc(s_inc), .s_inm(s_inm), .we3(we3), .wez(wez), .op(op), .s_ret(s_ret),
        .ret_addr(ret_addr), .zflag(zflag), .sp(sp), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] c_alu(input logic [2:0] o);
        return {4'b1011, o, 1'b0};
    endfunction

    function automatic vec_t mk(input string n, input logic rst, input logic [5:0] opc,
                                input logic zi, input logic [9:0] pc, input logic [7:0] ctl,
                                input logic [9:0] ret, input logic [3:0] spx, input logic zf,
                                input logic ovf, input logic unf);
        vec_t v;
        v.name = n; v.rst = rst; v.opc = opc; v.z = zi; v.pc = pc; v.ctl = ctl;
        v.ret = ret; v.sp = spx; v.zf = zf; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        reset = v.rst; opcode = v.opc; z = v.z; pc_plus1 = v.pc;
        sb.push_back(v);
    endtask

    // Monitor: decode outputs mid-cycle, registered state just after the edge.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                vec_t v;
                v = sb.pop_front();
                chk({v.name, " ctl"}, {24'd0, s_inc, s_inm, we3, wez, op, s_ret}, {24'd0, v.ctl});
                chk({v.name, " ret_addr"}, {22'd0, ret_addr}, {22'd0, v.ret});
                @(posedge clk);
                #1;
                chk({v.name, " sp"}, {28'd0, sp}, {28'd0, v.sp});
                chk({v.name, " zflag"}, {31'd0, zflag}, {31'd0, v.zf});
                chk({v.name, " stk_ovf"}, {31'd0, stk_ovf}, {31'd0, v.ovf});
                chk({v.name, " stk_unf"}, {31'd0, stk_unf}, {31'd0, v.unf});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; opcode = OP_NOP; z = 1'b0; pc_plus1 = '0;
        @(posedge clk);

        //                name       rst opcode      z  pc      ctl         ret     sp zf ov un
        tbl.push_back(mk("rst_jal0", 1, OP_JAL,      1, 10'h055, C_NOP,      10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("rst_jal1", 1, OP_JAL,      1, 10'h055, C_NOP,      10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("alu5_z1",  0, 6'b010100,   1, 10'h000, c_alu(3'd5), 10'h000, 0, 1, 0, 0));
        tbl.push_back(mk("jz_f1",    0, OP_JZ,       0, 10'h000, C_JMP,      10'h000, 0, 1, 0, 0));
        tbl.push_back(mk("jnz_f1",   0, OP_JNZ,      0, 10'h000, C_NOP,      10'h000, 0, 1, 0, 0));
        tbl.push_back(mk("alu0_z0",  0, 6'b000000,   0, 10'h000, c_alu(3'd0), 10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("jz_f0",    0, OP_JZ,       1, 10'h000, C_NOP,      10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("jnz_f0",   0, OP_JNZ,      1, 10'h000, C_JMP,      10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("j",        0, OP_J,        1, 10'h000, C_JMP,      10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("jal_012",  0, OP_JAL,      0, 10'h012, C_JMP,      10'h000, 1, 0, 0, 0));
        tbl.push_back(mk("jal_1a0",  0, OP_JAL,      0, 10'h1A0, C_JMP,      10'h012, 2, 0, 0, 0));
        tbl.push_back(mk("ret_1a0",  0, OP_RET,      0, 10'h000, C_RET,      10'h1A0, 1, 0, 0, 0));
        tbl.push_back(mk("ret_012",  0, OP_RET,      0, 10'h000, C_RET,      10'h012, 0, 0, 0, 0));
        tbl.push_back(mk("li",       0, OP_LI,       1, 10'h000, C_LI,       10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("undef3f",  0, OP_NOP,      1, 10'h000, C_NOP,      10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("undef26",  0, 6'b100110,   1, 10'h000, C_NOP,      10'h000, 0, 0, 0, 0));
        tbl.push_back(mk("alu7_z1",  0, 6'b011111,   1, 10'h000, c_alu(3'd7), 10'h000, 0, 1, 0, 0));
        tbl.push_back(mk("hold_zf",  0, OP_NOP,      0, 10'h000, C_NOP,      10'h000, 0, 1, 0, 0));

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // DEPTH+1 calls: the ninth is taken but not stored and flags overflow.
        for (int i = 1; i <= 9; i++) begin
            apply(mk($sformatf("jal_%0d", i), 0, OP_JAL, 0, 10'(i), C_JMP,
                     (i == 1) ? 10'd0 : 10'(i - 1), (i >= 8) ? 4'd8 : 4'(i), 1,
                     (i == 9), 0));
        end
        for (int k = 0; k < 8; k++) begin
            apply(mk($sformatf("ret_%0d", 8 - k), 0, OP_RET, 0, 10'h000, C_RET,
                     10'(8 - k), 4'(7 - k), 1, 1, 0));
        end
        apply(mk("ret_empty", 0, OP_RET, 0, 10'h000, C_RET, 10'h000, 0, 1, 1, 1));
        apply(mk("unf_sticky", 0, OP_NOP, 0, 10'h000, C_NOP, 10'h000, 0, 1, 1, 1));
        apply(mk("jal_3ff", 0, OP_JAL, 0, 10'h3FF, C_JMP, 10'h000, 1, 1, 1, 1));
        apply(mk("rst_ret", 1, OP_RET, 1, 10'h000, C_NOP, 10'h3FF, 0, 0, 0, 0));
        apply(mk("post_rst", 0, OP_NOP, 0, 10'h000, C_NOP, 10'h000, 0, 0, 0, 0));

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
